// File: rtl/counter_cmd_seq.sv
// rtl/counter_cmd_seq.sv - command sequencer that drives en/load/up_downN of an external up/down counter
// Accepts LOAD/UP/DOWN commands one at a time and issues the matching counter strobes.
module counter_cmd_seq (
  input  logic       clk,
  input  logic       resetN,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [4:0] cmd_arg,
  input  logic       abort,
  output logic       en,
  output logic       load,
  output logic       up_downN,
  output logic [4:0] initialCount,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       aborted
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;

  logic [1:0] state, state_nxt;
  logic [4:0] remaining, rem_nxt;
  logic       en_nxt, load_nxt, up_nxt, err_nxt, ab_nxt;
  logic [4:0] init_nxt;

  assign busy = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    rem_nxt   = remaining;
    en_nxt    = 1'b0;
    load_nxt  = 1'b0;
    up_nxt    = 1'b0;
    init_nxt  = 5'd0;
    err_nxt   = 1'b0;
    ab_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          case (cmd_op)
            OP_LOAD: begin
              state_nxt = S_LOAD;
              en_nxt    = 1'b1;
              load_nxt  = 1'b1;
              init_nxt  = cmd_arg;
            end
            OP_UP, OP_DOWN: begin
              if (cmd_arg == 5'd0) begin
                state_nxt = S_DONE;
              end else begin
                state_nxt = S_STEP;
                rem_nxt   = cmd_arg;
                en_nxt    = 1'b1;
                up_nxt    = (cmd_op == OP_UP);
              end
            end
            default: begin
              state_nxt = S_DONE;
              err_nxt   = 1'b1;
            end
          endcase
        end
      end
      S_LOAD: state_nxt = S_DONE;
      S_STEP: begin
        rem_nxt = remaining - 5'd1;
        // abort on the last step still reports as aborted
        if (abort || remaining == 5'd1) begin
          state_nxt = S_DONE;
          ab_nxt    = abort;
        end else begin
          en_nxt = 1'b1;
          up_nxt = up_downN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= S_IDLE;
      remaining    <= 5'd0;
      cmd_ready    <= 1'b0;
      en           <= 1'b0;
      load         <= 1'b0;
      up_downN     <= 1'b0;
      initialCount <= 5'd0;
      done         <= 1'b0;
      err          <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      state        <= state_nxt;
      remaining    <= rem_nxt;
      cmd_ready    <= (state_nxt == S_IDLE);
      en           <= en_nxt;
      load         <= load_nxt;
      up_downN     <= up_nxt;
      initialCount <= init_nxt;
      done         <= (state_nxt == S_DONE);
      err          <= err_nxt;
      aborted      <= ab_nxt;
    end
  end

endmodule

// File: doc/counter_cmd_seq.md
COUNTER_CMD_SEQ -- requirements
Module: counter_cmd_seq

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 resetN  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  sequencer can accept a command.
REQ-006 cmd_op  input  2  opcode: 00 LOAD, 01 UP, 10 DOWN, 11 reserved.
REQ-007 cmd_arg  input  5  load value (LOAD) or step count N (UP/DOWN).
REQ-008 abort  input  1  terminate an in-progress UP/DOWN run.
REQ-009 en  output  1  counter enable, registered.
REQ-010 load  output  1  counter load strobe, registered.
REQ-011 up_downN  output  1  direction: 1 up, 0 down, registered.
REQ-012 initialCount  output  5  load value, registered.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 done  output  1  one-cycle pulse on command completion.
REQ-015 err  output  1  one-cycle pulse, coincident with done, for a reserved opcode.
REQ-016 aborted  output  1  one-cycle pulse, coincident with done, when the run ended by abort.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, STEP and DONE.
REQ-018 A command SHALL be accepted only on a rising edge where cmd_valid=1 and cmd_ready=1; op and arg are latched at that edge.
REQ-019 cmd_ready SHALL be 1 only in IDLE; cmd_valid=1 with cmd_ready=0 SHALL be ignored, with no queuing.
REQ-020 LOAD accepted -> LOAD state for exactly 1 cycle with en=1, load=1, initialCount=arg -> DONE.
REQ-021 UP/DOWN accepted with N>0 -> STEP state for exactly N consecutive cycles with en=1, load=0, up_downN=(op==UP).
- A 5-bit remaining-count register is loaded with N and decremented each STEP cycle.
- On the edge where remaining==1, the FSM goes to DONE.
REQ-022 UP/DOWN with N=0 SHALL go directly to DONE with no en cycle.
REQ-023 Reserved op 11 SHALL go directly to DONE with no en cycle and err=1 in DONE.
REQ-024 DONE SHALL last exactly 1 cycle with done=1, then go to IDLE.
- A command is accepted on an edge where the FSM is in IDLE.
- Minimum accept-to-accept spacing: N+2 cycles for UP/DOWN with N>0, 3 cycles for LOAD, 2 cycles for N=0 or reserved.
REQ-025 N=31 SHALL produce 31 en cycles; counter wrap-around is the counter's concern, and the sequencer does not saturate.
REQ-026 Outside LOAD: load=0 and initialCount=0.
- Outside LOAD and STEP: en=0 and up_downN=0.
REQ-027 abort sampled 1 in STEP SHALL go to DONE on that edge with aborted=1.
- No further en cycles after that edge.
- Steps already issued stand.
REQ-028 abort SHALL be ignored in IDLE, LOAD and DONE.
- When abort coincides with the final STEP edge, aborted=1 is still flagged.
REQ-029 busy SHALL be 1 in LOAD, STEP and DONE, and 0 in IDLE.

Reset
REQ-030 resetN=0 SHALL force, immediately: state=IDLE, cmd_ready=0, en=0, load=0, up_downN=0, initialCount=0, busy=0, done=0, err=0, aborted=0, remaining=0.
REQ-031 cmd_ready SHALL rise on the first rising clk edge with resetN=1; no command is accepted before then.
REQ-032 Reset asserted mid-run SHALL abandon the command with no done pulse; en drops asynchronously.

Verification
REQ-033 LOAD arg=5'd19 -> next cycle: en=1, load=1, initialCount=19 for 1 cycle; then done=1 for 1 cycle; cmd_ready back 3 cycles after accept.
REQ-034 UP N=3 then DOWN N=2 back-to-back with cmd_valid held -> en high 3 cycles (up_downN=1), done, accept, en high 2 cycles (up_downN=0), done; a 5-bit counter goes 0->3->1.
REQ-035 UP N=0, then op=11 -> each gives done 1 cycle after accept with no en; err=1 only for op=11.
REQ-036 DOWN N=10 with abort pulsed in the 4th STEP cycle -> exactly 4 en cycles, then done=1 and aborted=1.
REQ-037 resetN pulsed low during STEP of UP N=20 -> all outputs 0 asynchronously, no done pulse; cmd_ready=1 on the first edge after release.
REQ-038 cmd_valid held high while busy with changing cmd_arg -> only the values present at the accept edge are used.
